// File: rtl/des_ip_loader.sv
// DES input stage: gathers eight bytes MSB-first into a 64-bit block, applies the
// initial permutation and holds L0/R0 for the round logic behind a valid/ready handshake.
module des_ip_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:8]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [1:32] left_out,
    output logic [1:32] right_out,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int IP_TBL [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    function automatic logic [1:64] ip_perm(input logic [1:64] m);
        logic [1:64] r;
        for (int i = 0; i < 64; i++) begin
            r[i+1] = m[IP_TBL[i]];
        end
        return r;
    endfunction

    logic [1:56] asm;
    logic [1:56] asm_next;
    logic [2:0]  cnt;
    logic        accept;
    logic        load;
    logic [1:64] blk_ip;

    // Only the completing byte has to wait for the output register to free up.
    always_comb begin
        in_ready = !flush && ((cnt != 3'd7) || !out_valid || out_ready);
        accept   = in_valid && in_ready;
        load     = accept && (cnt == 3'd7);
        blk_ip   = ip_perm({asm, in_byte});
        asm_next = asm;
        for (int k = 0; k < 7; k++) begin
            if (cnt == 3'(k)) begin
                asm_next[8*k+1 +: 8] = in_byte;
            end
        end
    end

    // Collection stage: byte counter and assembly register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 3'd0;
            asm <= '0;
        end else if (flush) begin
            cnt <= 3'd0;
        end else if (accept) begin
            if (cnt == 3'd7) begin
                cnt <= 3'd0;
            end else begin
                cnt <= cnt + 3'd1;
                asm <= asm_next;
            end
        end
    end

    // Output stage: a load in the same cycle as a consume keeps out_valid high
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            left_out  <= '0;
            right_out <= '0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                left_out  <= blk_ip[1:32];
                right_out <= blk_ip[33:64];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_des_ip_loader.sv
// Directed bench for des_ip_loader: byte-queue reference model checked every cycle,
// literal vectors for the known cases, and a final-permutation round trip.
module tb_des_ip_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:8]  in_byte = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [1:32] left_out;
    logic [1:32] right_out;
    logic        out_valid;
    logic        out_ready = 1'b1;

    des_ip_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .left_out  (left_out),
        .right_out (right_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    bit rt_en  = 1'b0;
    int rt_seen = 0;

    logic [7:0]  mq[$];
    logic [63:0] sent[$];
    logic [63:0] mout = '0;
    bit          mov  = 1'b0;

    localparam int FP_TBL [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    // IP by its arithmetic structure: rows 0-3 take even source bits, rows 4-7 odd ones.
    function automatic logic [63:0] ip_model(input logic [63:0] m);
        logic [63:0] r;
        int row, col, src;
        for (int i = 1; i <= 64; i++) begin
            row = (i - 1) / 8;
            col = (i - 1) % 8;
            src = (row < 4) ? (58 + 2*row - 8*col) : (57 + 2*(row - 4) - 8*col);
            r[64-i] = m[64-src];
        end
        return r;
    endfunction

    function automatic logic [63:0] fp_model(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 1; i <= 64; i++) begin
            r[64-i] = x[64-FP_TBL[i-1]];
        end
        return r;
    endfunction

    function automatic bit exp_rdy();
        return !flush && ((mq.size() != 7) || !mov || out_ready);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: updated on each rising edge from the inputs the DUT sees.
    logic [63:0] m_asm;
    bit acc, cons;
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            mov  = 1'b0;
            mout = '0;
        end else begin
            acc  = in_valid && exp_rdy();
            cons = mov && out_ready;
            if (cons) mov = 1'b0;
            if (flush) begin
                mq.delete();
            end else if (acc) begin
                mq.push_back(in_byte);
                if (mq.size() == 8) begin
                    m_asm = '0;
                    foreach (mq[i]) m_asm = {m_asm[55:0], mq[i]};
                    mout = ip_model(m_asm);
                    mov  = 1'b1;
                    mq.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", 64'(in_ready), 64'(exp_rdy()));
            chk("out_valid", 64'(out_valid), 64'(mov));
            chk("out_data", {left_out, right_out}, mout);
        end
        if (rt_en && out_valid && out_ready) begin
            rt_seen++;
            if (sent.size() == 0) begin
                chk("rt_unexpected_block", {left_out, right_out}, 64'h0);
            end else begin
                chk("round_trip", fp_model({left_out, right_out}), sent.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int budget;
        bit ok;
        budget = 200;
        ok = 1'b0;
        while (rnd && $urandom_range(0, 3) == 0) begin
            in_valid  = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b1;
        in_byte  = b;
        do begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            ok = in_ready;
            tick();
            budget--;
        end while (!ok && budget > 0);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout: got in_ready=0 for 200 cycles expected acceptance");
        end
        in_valid = 1'b0;
    endtask

    task automatic send_block(input logic [63:0] m, input bit rnd);
        for (int i = 0; i < 8; i++) begin
            send_byte(m[63-8*i -: 8], rnd);
        end
    endtask

    task automatic expect_out(input string name, input logic [31:0] l, input logic [31:0] r);
        @(negedge clk);
        chk({name, "_valid"}, 64'(out_valid), 64'h1);
        chk({name, "_left"}, 64'(left_out), 64'(l));
        chk({name, "_right"}, 64'(right_out), 64'(r));
    endtask

    localparam logic [63:0] VEC1 = 64'h0123456789ABCDEF;

    initial begin
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;

        // Known vector, one-cycle out_valid pulse
        out_ready = 1'b1;
        send_block(VEC1, 1'b0);
        expect_out("vec1", 32'hCC00CCFF, 32'hF0AAF0AA);
        @(negedge clk);
        chk("vec1_pulse_end", 64'(out_valid), 64'h0);

        // Single-bit mapping
        tick();
        send_block(64'h0000000000000040, 1'b0);
        expect_out("bit58", 32'h80000000, 32'h00000000);
        tick();
        send_block(64'h8000000000000000, 1'b0);
        expect_out("bit1", 32'h00000000, 32'h01000000);
        tick();
        tick();

        // Backpressure: next block collects behind a held output
        out_ready = 1'b0;
        send_block(VEC1, 1'b0);
        for (int i = 0; i < 7; i++) send_byte(8'hFF, 1'b0);
        in_valid = 1'b1;
        in_byte  = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready_low", 64'(in_ready), 64'h0);
            chk("bp_hold_left", 64'(left_out), 64'hCC00CCFF);
            chk("bp_hold_right", 64'(right_out), 64'hF0AAF0AA);
        end
        tick();
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        expect_out("bp_replace", 32'hFFFFFFFF, 32'hFFFFFFFF);
        tick();
        tick();

        // Flush mid-block, with a byte presented during the flush
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'h55;
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 64'h0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        send_block(VEC1, 1'b0);
        expect_out("flush_vec1", 32'hCC00CCFF, 32'hF0AAF0AA);
        tick();

        // Reset mid-block with a held output
        out_ready = 1'b0;
        send_block(64'h0000000000000040, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_left", 64'(left_out), 64'h0);
        chk("rst_right", 64'(right_out), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        send_block(VEC1, 1'b0);
        expect_out("rst_vec1", 32'hCC00CCFF, 32'hF0AAF0AA);
        tick();
        tick();

        // Round trip through the final permutation with random gaps
        sent.delete();
        rt_en = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            logic [63:0] m;
            m = {$urandom, $urandom};
            sent.push_back(m);
            send_block(m, 1'b1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        rt_en = 1'b0;
        chk("rt_drained", 64'(sent.size()), 64'h0);
        chk("rt_count", 64'(rt_seen), 64'd1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion expected $finish before 900000");
        $fatal(1, "watchdog expired");
    end

endmodule
